hit_resolver: RTL and testbench

Combat stage directly downstream of `player_move` and `player_attack`. Once per frame tick it tests the attacker's active hitbox against the defender's hurtbox and applies damage at most once per attack activation. It maintains the defender's health, hitstun countdown and KO flag. One instance per attacker→defender direction; `def_stunned` feeds the defender's `move_enable` and `attack_enable` (inverted).

---
 rtl/hit_resolver.sv | 143 ++++++++++++++
 tb/tb_hit_resolver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_resolver.sv
// Per-frame hit resolution from one attacker to one defender.
// Tracks the defender's health, hitstun and KO, and lands at most one hit per attack activation.
module hit_resolver #(
  parameter int BOX_W  = 60,
  parameter int BOX_H  = 60,
  parameter int ATK1_W = 30,
  parameter int ATK2_W = 60,
  parameter int DMG1   = 8,
  parameter int DMG2   = 15,
  parameter int STUN1  = 12,
  parameter int STUN2  = 20,
  parameter int MAX_HP = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SCEN,
  input  logic       new_round,
  input  logic       atk_active,
  input  logic [1:0] atk_type,
  input  logic [9:0] atk_x,
  input  logic [9:0] atk_y,
  input  logic       atk_facing_right,
  input  logic [9:0] def_x,
  input  logic [9:0] def_y,
  input  logic       def_block,
  output logic       hit_pulse,
  output logic [1:0] hit_type,
  output logic [7:0] def_health,
  output logic       def_stunned,
  output logic       ko
);

  // state     | meaning
  // S_IDLE    | no attack in progress
  // S_ARMED   | attack active, not yet connected
  // S_CONN    | attack active, hit already landed
  // S_KOED    | defender knocked out, waits for new_round
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_CONN  = 2'd2;
  localparam logic [1:0] S_KOED  = 2'd3;

  localparam logic [10:0] BW  = 11'(BOX_W);
  localparam logic [10:0] BH  = 11'(BOX_H);
  localparam logic [10:0] AW1 = 11'(ATK1_W);
  localparam logic [10:0] AW2 = 11'(ATK2_W);
  localparam logic [7:0]  D1  = 8'(DMG1);
  localparam logic [7:0]  D2  = 8'(DMG2);
  localparam logic [5:0]  ST1 = 6'(STUN1);
  localparam logic [5:0]  ST2 = 6'(STUN2);
  localparam logic [7:0]  HP0 = 8'(MAX_HP);

  logic [1:0]  state;
  logic [1:0]  lat_type;
  logic [5:0]  stun;

  logic [1:0]  eff_type;
  logic [10:0] hb_w, hx0, hx1, ax, ay, dx, dy;
  logic        overlap, valid_type, take_hit;
  logic [7:0]  dmg_raw, dmg, health_next;
  logic [5:0]  stun_load;

  // In IDLE the incoming type is the one being latched this cycle, so geometry uses it directly.
  always_comb begin
    eff_type   = (state == S_IDLE) ? atk_type : lat_type;
    valid_type = (atk_type == 2'd1) || (atk_type == 2'd2);
    hb_w       = (eff_type == 2'd2) ? AW2 : AW1;
    ax         = {1'b0, atk_x};
    ay         = {1'b0, atk_y};
    dx         = {1'b0, def_x};
    dy         = {1'b0, def_y};
    if (atk_facing_right) begin
      hx0 = ax + BW;
      hx1 = ax + BW + hb_w;
    end else begin
      hx0 = (ax >= hb_w) ? (ax - hb_w) : 11'd0;
      hx1 = ax;
    end
    overlap = (hx0 < dx + BW) && (dx < hx1) && (ay < dy + BH) && (dy < ay + BH);

    take_hit = 1'b0;
    case (state)
      S_IDLE:  take_hit = atk_active && valid_type && overlap;
      S_ARMED: take_hit = atk_active && overlap;
      default: take_hit = 1'b0;
    endcase

    dmg_raw     = (eff_type == 2'd2) ? D2 : D1;
    dmg         = def_block ? (dmg_raw >> 2) : dmg_raw;
    health_next = (def_health > dmg) ? (def_health - dmg) : 8'd0;
    stun_load   = (eff_type == 2'd2) ? ST2 : ST1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      lat_type   <= 2'd0;
      stun       <= 6'd0;
      def_health <= HP0;
      hit_pulse  <= 1'b0;
      hit_type   <= 2'd0;
      ko         <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;
      if (new_round) begin
        state      <= S_IDLE;
        stun       <= 6'd0;
        def_health <= HP0;
        ko         <= 1'b0;
      end else if (SCEN) begin
        if (stun != 6'd0) stun <= stun - 6'd1;
        case (state)
          S_IDLE: begin
            if (atk_active && valid_type) begin
              lat_type <= atk_type;
              state    <= S_ARMED;
            end
          end
          S_ARMED, S_CONN: begin
            if (!atk_active) state <= S_IDLE;
          end
          default: state <= S_KOED;
        endcase
        // Later assignments intentionally override the plain FSM/stun updates above.
        if (take_hit) begin
          hit_pulse  <= 1'b1;
          hit_type   <= eff_type;
          def_health <= health_next;
          if (!def_block) stun <= stun_load;
          if (health_next == 8'd0) begin
            ko    <= 1'b1;
            state <= S_KOED;
          end else begin
            state <= S_CONN;
          end
        end
      end
    end
  end

  assign def_stunned = (stun != 6'd0);

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver with a frame-level reference model checked every cycle.
module tb_hit_resolver;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       SCEN = 1'b0;
  logic       new_round = 1'b0;
  logic       atk_active = 1'b0;
  logic [1:0] atk_type = 2'd1;
  logic [9:0] atk_x = 10'd200, atk_y = 10'd300, def_x = 10'd280, def_y = 10'd300;
  logic       atk_facing_right = 1'b1;
  logic       def_block = 1'b0;
  logic       hit_pulse, def_stunned, ko;
  logic [1:0] hit_type;
  logic [7:0] def_health;

  int n_cmp = 0, n_fail = 0, pcount = 0;
  bit run = 0;

  // reference model state
  int m_health = 100, m_stun = 0, m_type = 0, m_lt = 0;
  bit m_ko = 0, m_pulse = 0, m_engaged = 0, m_landed = 0;

  hit_resolver dut (
    .clk(clk), .reset_n(reset_n), .SCEN(SCEN), .new_round(new_round),
    .atk_active(atk_active), .atk_type(atk_type), .atk_x(atk_x), .atk_y(atk_y),
    .atk_facing_right(atk_facing_right), .def_x(def_x), .def_y(def_y),
    .def_block(def_block), .hit_pulse(hit_pulse), .hit_type(hit_type),
    .def_health(def_health), .def_stunned(def_stunned), .ko(ko)
  );

  always #20 clk = ~clk;

  function automatic bit overlaps(int t);
    int w, lo, hi, ax, ay, dx, dy;
    w  = (t == 2) ? 60 : 30;
    ax = int'(atk_x); ay = int'(atk_y); dx = int'(def_x); dy = int'(def_y);
    if (atk_facing_right) begin
      lo = ax + 60; hi = lo + w;
    end else begin
      lo = (ax >= w) ? ax - w : 0; hi = ax;
    end
    return (lo < dx + 60) && (dx < hi) && (ay < dy + 60) && (dy < ay + 60);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_health = 100; m_stun = 0; m_type = 0; m_ko = 0; m_pulse = 0;
      m_engaged = 0; m_landed = 0;
    end else begin
      m_pulse = 0;
      if (new_round) begin
        m_health = 100; m_stun = 0; m_ko = 0; m_engaged = 0; m_landed = 0;
      end else if (SCEN) begin
        bit hit;
        int nstun, d;
        hit = 0;
        nstun = (m_stun > 0) ? m_stun - 1 : 0;
        if (!m_ko) begin
          if (!m_engaged) begin
            if (atk_active && (atk_type == 1 || atk_type == 2)) begin
              m_engaged = 1; m_landed = 0; m_lt = int'(atk_type);
              hit = overlaps(m_lt);
            end
          end else if (!atk_active) begin
            m_engaged = 0;
          end else if (!m_landed) begin
            hit = overlaps(m_lt);
          end
        end
        if (hit) begin
          m_landed = 1;
          d = (m_lt == 2) ? 15 : 8;
          if (def_block) d = d / 4;
          else nstun = (m_lt == 2) ? 20 : 12;
          m_health = (m_health > d) ? m_health - d : 0;
          m_type = m_lt;
          m_pulse = 1;
          if (m_health == 0) m_ko = 1;
        end
        m_stun = nstun;
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("pulse", int'(hit_pulse), int'(m_pulse));
      chk("type", int'(hit_type), m_type);
      chk("health", int'(def_health), m_health);
      chk("stunned", int'(def_stunned), int'(m_stun != 0));
      chk("ko", int'(ko), int'(m_ko));
      if (hit_pulse) pcount++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic frame();
    tick(); tick();
    SCEN = 1'b1;
    tick();
    SCEN = 1'b0;
  endtask

  task automatic nr();
    new_round = 1'b1;
    tick();
    new_round = 1'b0;
  endtask

  task automatic attack(logic [1:0] t, logic blk);
    atk_type = t; def_block = blk; atk_active = 1'b1;
    frame();
    atk_active = 1'b0;
    frame();
  endtask

  initial begin
    int p0;
    run = 1;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("rst_health", int'(def_health), 100);
    chk("rst_ko", int'(ko), 0);
    chk("rst_type", int'(hit_type), 0);
    chk("rst_stunned", int'(def_stunned), 0);

    // light hit, right facing
    atk_type = 2'd1; atk_active = 1'b1;
    frame();
    chk("hit1_pulse", int'(hit_pulse), 1);
    chk("hit1_health", int'(def_health), 92);
    chk("hit1_stunned", int'(def_stunned), 1);
    atk_active = 1'b0;
    tick();
    chk("hit1_pulse_off", int'(hit_pulse), 0);
    repeat (11) frame();
    chk("stun_11", int'(def_stunned), 1);
    frame();
    chk("stun_12", int'(def_stunned), 0);

    // touching edge
    nr();
    def_x = 10'd290; atk_active = 1'b1;
    frame();
    chk("touch_pulse", int'(hit_pulse), 0);
    chk("touch_health", int'(def_health), 100);
    atk_active = 1'b0;
    frame();

    // left facing, clamped hitbox, held for 10 frames
    atk_facing_right = 1'b0; atk_x = 10'd20; def_x = 10'd0; atk_type = 2'd2;
    p0 = pcount;
    atk_active = 1'b1;
    repeat (10) frame();
    atk_active = 1'b0;
    tick();
    chk("left_health", int'(def_health), 85);
    chk("left_one_hit", pcount - p0, 1);
    frame();

    // blocked heavy
    nr();
    atk_facing_right = 1'b1; atk_x = 10'd200; def_x = 10'd280;
    attack(2'd2, 1'b1);
    chk("block_health", int'(def_health), 97);
    chk("block_stunned", int'(def_stunned), 0);

    // drive health to 5, then KO
    repeat (6) attack(2'd2, 1'b0);
    attack(2'd1, 1'b1);
    chk("pre_ko_health", int'(def_health), 5);
    atk_type = 2'd1; def_block = 1'b0; atk_active = 1'b1;
    frame();
    chk("ko_health", int'(def_health), 0);
    chk("ko_flag", int'(ko), 1);
    chk("ko_pulse", int'(hit_pulse), 1);
    atk_active = 1'b0;
    frame();
    p0 = pcount;
    attack(2'd1, 1'b0);
    attack(2'd2, 1'b0);
    chk("after_ko_pulses", pcount - p0, 0);
    nr();
    chk("nr_health", int'(def_health), 100);
    chk("nr_ko", int'(ko), 0);

    // reset mid-stun
    attack(2'd1, 1'b0);
    frame();
    atk_active = 1'b1;
    frame();
    reset_n = 1'b0;
    #1;
    chk("arst_health", int'(def_health), 100);
    chk("arst_stunned", int'(def_stunned), 0);
    atk_active = 1'b0;
    tick(); tick(); tick();
    reset_n = 1'b1;
    tick();

    // new_round coincident with hitting SCEN
    attack(2'd1, 1'b0);
    chk("pre_nr_health", int'(def_health), 92);
    atk_active = 1'b1;
    tick(); tick();
    new_round = 1'b1; SCEN = 1'b1;
    tick();
    new_round = 1'b0; SCEN = 1'b0; atk_active = 1'b0;
    chk("nr_scen_pulse", int'(hit_pulse), 0);
    chk("nr_scen_health", int'(def_health), 100);
    frame();

    // invalid types ignored
    p0 = pcount;
    atk_type = 2'd3; atk_active = 1'b1;
    frame();
    atk_type = 2'd0;
    frame();
    atk_active = 1'b0;
    frame();
    chk("invalid_pulses", pcount - p0, 0);
    chk("invalid_health", int'(def_health), 100);

    tick(); tick();
    run = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
